// File: rtl/color_light_pkg.sv
// Shared mode/speed codes and their cycling order for the colour light controller.
package color_light_pkg;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned SPEED_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic [SPEED_W-1:0] {
    SPEED_0 = 2'd0,
    SPEED_1 = 2'd1,
    SPEED_2 = 2'd2
  } speed_e;

  // Mode key walks OFF -> CHASE -> BLINK -> BREATHE -> OFF.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_OFF:   return MODE_CHASE;
      MODE_CHASE: return MODE_BLINK;
      MODE_BLINK: return MODE_BREATHE;
      default:    return MODE_OFF;
    endcase
  endfunction

  // Speed key walks 0 -> 1 -> 2 -> 0; code 3 is unused.
  function automatic speed_e next_speed(input speed_e s);
    case (s)
      SPEED_0: return SPEED_1;
      SPEED_1: return SPEED_2;
      default: return SPEED_0;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, ms-tick debounce and a one-cycle press pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ms_tick_i,
  input  logic key_i,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Level flips only after DEBOUNCE_MS consecutive disagreeing ticks; a rising flip yields a press.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (ms_tick_i) begin
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_d = sync2_q;
          cnt_d   = '0;
          press_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Synchronizer and debounce state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/color_light_ctrl.sv
// Two-key LED pattern controller: off / chase / blink / breathe at three speeds.
module color_light_ctrl
  import color_light_pkg::*;
#(
  parameter int unsigned N_LED       = 4,
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned STEP_MS     = 500,
  parameter int unsigned PWM_BITS    = 4
) (
  input  logic             Sys_CLK,
  input  logic             Sys_RST,
  input  logic [1:0]       Key,
  output logic [N_LED-1:0] LED,
  output logic [1:0]       Mode,
  output logic [1:0]       Speed
);

  localparam int unsigned TICK_DIV = CLK_HZ / 1000;
  localparam int unsigned MS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned STEP_W   = $clog2(STEP_MS + 1);
  localparam int unsigned POS_W    = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam logic [MS_W-1:0]     MS_LAST  = MS_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0]    POS_LAST = POS_W'(N_LED - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;

  logic [MS_W-1:0]     ms_cnt_q;
  logic                ms_tick_c;
  logic [1:0]          key_press;
  mode_e               mode_q, mode_d;
  speed_e              speed_q, speed_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d, step_last_c;
  logic                step_c;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                blink_q, blink_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                down_q, down_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [N_LED-1:0]    led_d, led_q;
  logic [1:0]          mode_out_q, speed_out_q;

  assign ms_tick_c   = (ms_cnt_q == MS_LAST);
  assign step_last_c = STEP_W'((STEP_MS >> speed_q) - 32'd1);

  for (genvar i = 0; i < 2; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_key_debounce (
      .clk_i    (Sys_CLK),
      .rst_i    (Sys_RST),
      .ms_tick_i(ms_tick_c),
      .key_i    (Key[i]),
      .press_o  (key_press[i])
    );
  end

  // Mode/speed updates, step timing and pattern state advance.
  always_comb begin
    mode_d     = mode_q;
    speed_d    = speed_q;
    step_cnt_d = step_cnt_q;
    pos_d      = pos_q;
    blink_d    = blink_q;
    level_d    = level_q;
    down_d     = down_q;
    step_c     = 1'b0;

    if (key_press[1]) speed_d = next_speed(speed_q);

    if (key_press[0]) begin
      mode_d     = next_mode(mode_q);
      step_cnt_d = '0;
      pos_d      = '0;
      blink_d    = 1'b1;
      level_d    = '0;
      down_d     = 1'b0;
    end else if (key_press[1]) begin
      step_cnt_d = '0;
    end else if (ms_tick_c) begin
      if (step_cnt_q == step_last_c) begin
        step_cnt_d = '0;
        step_c     = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + 1'b1;
      end
    end

    if (step_c) begin
      case (mode_q)
        MODE_CHASE: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        MODE_BLINK: blink_d = ~blink_q;
        MODE_BREATHE: begin
          // Triangle turns around at the ends without repeating the end value.
          if (!down_q) begin
            if (level_q == LVL_MAX) begin
              level_d = level_q - 1'b1;
              down_d  = 1'b1;
            end else begin
              level_d = level_q + 1'b1;
            end
          end else begin
            if (level_q == '0) begin
              level_d = level_q + 1'b1;
              down_d  = 1'b0;
            end else begin
              level_d = level_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // LED drive derived from the current pattern state.
  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_CHASE:   led_d = N_LED'(1) << pos_q;
      MODE_BLINK:   led_d = {N_LED{blink_q}};
      MODE_BREATHE: led_d = {N_LED{pwm_cnt_q < level_q}};
      default:      led_d = '0;
    endcase
  end

  // State, free-running counters and registered outputs.
  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      ms_cnt_q    <= '0;
      mode_q      <= MODE_OFF;
      speed_q     <= SPEED_0;
      step_cnt_q  <= '0;
      pos_q       <= '0;
      blink_q     <= 1'b0;
      level_q     <= '0;
      down_q      <= 1'b0;
      pwm_cnt_q   <= '0;
      led_q       <= '0;
      mode_out_q  <= '0;
      speed_out_q <= '0;
    end else begin
      ms_cnt_q    <= ms_tick_c ? '0 : ms_cnt_q + 1'b1;
      mode_q      <= mode_d;
      speed_q     <= speed_d;
      step_cnt_q  <= step_cnt_d;
      pos_q       <= pos_d;
      blink_q     <= blink_d;
      level_q     <= level_d;
      down_q      <= down_d;
      pwm_cnt_q   <= pwm_cnt_q + 1'b1;
      led_q       <= led_d;
      mode_out_q  <= mode_q;
      speed_out_q <= speed_q;
    end
  end

  assign LED   = led_q;
  assign Mode  = mode_out_q;
  assign Speed = speed_out_q;

endmodule
